// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: registered 1-to-4 stream demultiplexer.
// Each input beat is steered by in_sel into one of four independent
// per-channel FIFOs; a stalled consumer only blocks its own channel.
module demux_1x4_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [4][DEPTH];
  logic [AW-1:0]    r_wrptr [4];
  logic [AW-1:0]    r_rdptr [4];
  logic [AW:0]      r_cnt [4];

  logic [3:0]       w_push;
  logic [3:0]       w_pop;

  // Acceptance depends only on registered occupancy of the selected channel,
  // so a pop on a full channel cannot free space for a push on the same edge.
  assign in_ready = !rst && (r_cnt[in_sel] != CNT_FULL);

  // Per-channel push/pop strobes and head-entry presentation.
  always_comb begin
    w_push    = '0;
    w_pop     = '0;
    out_valid = '0;
    out_data  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      out_valid[k] = (r_cnt[k] != '0);
      w_push[k]    = in_valid && in_ready && (in_sel == 2'(k));
      w_pop[k]     = out_valid[k] && out_ready[k];
      if (out_valid[k])
        out_data[k*WIDTH +: WIDTH] = r_mem[k][r_rdptr[k]];
    end
  end

  assign busy = |out_valid;

  // FIFO storage, pointers and occupancy; reset discards every buffered beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_wrptr[i] <= '0;
        r_rdptr[i] <= '0;
        r_cnt[i]   <= '0;
        for (int unsigned j = 0; j < DEPTH; j++)
          r_mem[i][j] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_push[k]) begin
          r_mem[k][r_wrptr[k]] <= in_data;
          r_wrptr[k]           <= r_wrptr[k] + 1'b1;
        end
        if (w_pop[k])
          r_rdptr[k] <= r_rdptr[k] + 1'b1;
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + 1'b1;
          2'b01:   r_cnt[k] <= r_cnt[k] - 1'b1;
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream: vector table, directed corner
// sequences and a random run checked against a queue-based reference model.
module tb_demux_1x4_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_1x4_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  // Reference model: one queue of pending beats per channel.
  logic [7:0] q [4][$];

  logic        e_ir;
  logic [3:0]  e_ov;
  logic [31:0] e_data;
  logic        e_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_outputs();
    e_ir   = !rst && (q[in_sel].size() < DEPTH);
    e_ov   = '0;
    e_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() != 0) begin
        e_ov[k]          = 1'b1;
        e_data[k*8 +: 8] = q[k][0];
      end
    end
    e_busy = (e_ov != 0);
  endfunction

  // Drive inputs shortly after a rising edge and let them settle.
  task automatic apply(input logic r, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] o);
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = o;
    #3;
  endtask

  // Compare against the model, advance the model by one edge, then clock.
  task automatic step(input bit do_check);
    logic acc;
    logic [3:0] pops;
    model_outputs();
    if (do_check) begin
      chk("in_ready",  {31'b0, in_ready}, {31'b0, e_ir});
      chk("out_valid", {28'b0, out_valid}, {28'b0, e_ov});
      chk("out_data",  out_data, e_data);
      chk("busy",      {31'b0, busy}, {31'b0, e_busy});
    end
    acc  = in_valid && e_ir;
    pops = e_ov & out_ready;
    if (rst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) if (pops[k]) void'(q[k].pop_front());
      if (acc) q[in_sel].push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic [1:0]  s;
    logic [7:0]  d;
    logic [3:0]  o;
    logic        eir;
    logic [3:0]  eov;
    logic [31:0] edat;
    logic        ebusy;
  } vec_t;

  vec_t tbl[8];

  logic [1:0] r_sel;
  logic [7:0] r_dat;
  logic       r_v;
  logic       stalled;

  initial begin
    // Reset with a beat presented, then route A0..A3 to channels 0..3.
    tbl[0] = '{1'b1, 1'b1, 2'd0, 8'hEE, 4'hF, 1'b0, 4'b0000, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 1'b1, 2'd1, 8'hEF, 4'hF, 1'b0, 4'b0000, 32'h0,         1'b0};
    tbl[2] = '{1'b0, 1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0000, 32'h0,         1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0001, 32'h0000_00A0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0010, 32'h0000_A100, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b0100, 32'h00A2_0000, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b1000, 32'hA300_0000, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h0,         1'b0};

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    @(posedge clk); #1;
    apply(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
    step(1'b0);

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].o);
      chk("tbl_in_ready",  {31'b0, in_ready},  {31'b0, tbl[i].eir});
      chk("tbl_out_valid", {28'b0, out_valid}, {28'b0, tbl[i].eov});
      chk("tbl_out_data",  out_data, tbl[i].edat);
      chk("tbl_busy",      {31'b0, busy},      {31'b0, tbl[i].ebusy});
      step(1'b1);
    end

    // Full channel 2 with its consumer stalled; channel 1 keeps flowing.
    apply(1'b0, 1'b1, 2'd2, 8'h10, 4'b1011); step(1'b1);
    apply(1'b0, 1'b1, 2'd2, 8'h11, 4'b1011);
    chk("bp_ir_second", {31'b0, in_ready}, 32'd1);
    step(1'b1);
    apply(1'b0, 1'b1, 2'd2, 8'h12, 4'b1011);
    chk("bp_ir_full", {31'b0, in_ready}, 32'd0);
    chk("bp_head10", {24'b0, out_data[23:16]}, 32'h10);
    step(1'b1);
    apply(1'b0, 1'b1, 2'd1, 8'h20, 4'b1011);
    chk("bp_ch1_ir", {31'b0, in_ready}, 32'd1);
    step(1'b1);
    apply(1'b0, 1'b1, 2'd2, 8'h12, 4'b1111);
    chk("bp_no_ready_path", {31'b0, in_ready}, 32'd0);
    chk("bp_pop10", {24'b0, out_data[23:16]}, 32'h10);
    step(1'b1);
    apply(1'b0, 1'b1, 2'd2, 8'h12, 4'b1111);
    chk("bp_ir_freed", {31'b0, in_ready}, 32'd1);
    chk("bp_pop11", {24'b0, out_data[23:16]}, 32'h11);
    step(1'b1);
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    chk("bp_pop12", {24'b0, out_data[23:16]}, 32'h12);
    step(1'b1);
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    chk("bp_drained", {31'b0, busy}, 32'd0);
    step(1'b1);

    // Continuous push/pop on channel 0 at occupancy 1, across pointer wraps.
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 1'b1, 2'd0, 8'(i), 4'b1111);
      if (i > 0) begin
        chk("pp_ir", {31'b0, in_ready}, 32'd1);
        chk("pp_valid", {31'b0, out_valid[0]}, 32'd1);
        chk("pp_data", {24'b0, out_data[7:0]}, 32'(i - 1));
      end
      step(1'b1);
    end
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    chk("pp_last", {24'b0, out_data[7:0]}, 32'h13);
    step(1'b1);
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    chk("pp_empty", {28'b0, out_valid}, 32'd0);
    step(1'b1);

    // Reset while channel 3 holds two beats.
    apply(1'b0, 1'b1, 2'd3, 8'h30, 4'b0000); step(1'b1);
    apply(1'b0, 1'b1, 2'd3, 8'h31, 4'b0000); step(1'b1);
    apply(1'b0, 1'b0, 2'd3, 8'h00, 4'b0000);
    chk("mr_held", {28'b0, out_valid}, 32'b1000);
    step(1'b1);
    apply(1'b1, 1'b1, 2'd3, 8'h32, 4'b0000);
    chk("mr_rst_ir", {31'b0, in_ready}, 32'd0);
    step(1'b1);
    apply(1'b0, 1'b1, 2'd3, 8'h55, 4'b1111);
    chk("mr_flushed", {28'b0, out_valid}, 32'd0);
    chk("mr_ir_back", {31'b0, in_ready}, 32'd1);
    step(1'b1);
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    chk("mr_new_beat", out_data, 32'h5500_0000);
    step(1'b1);
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    chk("mr_idle", {31'b0, busy}, 32'd0);
    step(1'b1);

    // Random traffic; a refused beat is held until accepted.
    stalled = 1'b0;
    r_sel = '0; r_dat = '0; r_v = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (!stalled) begin
        r_v   = ($urandom_range(0, 3) != 0);
        r_sel = 2'($urandom_range(0, 3));
        r_dat = 8'($urandom);
      end
      apply(($urandom_range(0, 499) == 0), r_v, r_sel, r_dat, 4'($urandom));
      model_outputs();
      stalled = r_v && !e_ir && !rst;
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
